// File: rtl/booth_step_sequencer.sv
// booth_step_sequencer: steps the Booth multiplier datapath through N iterations.
// A sequence is requested with start and is given a step count on term_count.
// The block runs IDLE -> RUN (count 0..N-1) -> DONE (one cycle) and returns to IDLE.
// enable stalls the count and abort cancels the run. auto_restart reruns the latched N.
// Every output is either a register or a decode of registered state.
module booth_step_sequencer #(
  parameter int MAX_COUNT = 32,
  parameter int NBITS     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NBITS-1:0] term_count,
  input  logic             enable,
  input  logic             abort,
  input  logic             auto_restart,
  output logic [NBITS-1:0] count,
  output logic             busy,
  output logic             flagStart,
  output logic             flagLast,
  output logic             flagReady,
  output logic             start_err,
  output logic [1:0]       state_dbg
);

  // Start handshake: a start request is accepted in IDLE (if abort is low) and in DONE.
  // It is accepted in the same cycle that start is high, and term_count is latched on
  // that edge. There is no ready signal. A start in RUN is dropped, and start_err
  // reports it one cycle later as a single-cycle pulse.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] count_q, count_nxt;
  logic [NBITS-1:0] n_lat, n_lat_nxt;
  logic             start_err_q, start_err_nxt;
  logic [NBITS-1:0] last_idx;

  // Map a requested step count into the legal range 1..MAX_COUNT.
  function automatic logic [NBITS-1:0] clamp_n(input logic [NBITS-1:0] tc);
    logic [NBITS-1:0] r;
    if (tc == '0) begin
      r = NBITS'(1);
    end else if (tc > NBITS'(MAX_COUNT)) begin
      r = NBITS'(MAX_COUNT);
    end else begin
      r = tc;
    end
    return r;
  endfunction

  assign last_idx = n_lat - NBITS'(1);

  // State, step counter, latched step count and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      count_q     <= '0;
      n_lat       <= NBITS'(1);
      start_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      count_q     <= count_nxt;
      n_lat       <= n_lat_nxt;
      start_err_q <= start_err_nxt;
    end
  end

  // Next-state logic. In RUN, abort wins over enable and start. In DONE the exits
  // are tried in the order abort, start, auto_restart.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count_q;
    n_lat_nxt     = n_lat;
    start_err_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        count_nxt = '0;
        if (start && !abort) begin
          state_nxt = ST_RUN;
          n_lat_nxt = clamp_n(term_count);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else begin
          start_err_nxt = start;
          if (enable) begin
            if (count_q == last_idx) begin
              state_nxt = ST_DONE;
              count_nxt = '0;
            end else begin
              count_nxt = count_q + NBITS'(1);
            end
          end
        end
      end
      ST_DONE: begin
        count_nxt = '0;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          state_nxt = ST_RUN;
          n_lat_nxt = clamp_n(term_count);
        end else if (auto_restart) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  assign count     = count_q;
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign flagStart = (state == ST_RUN) && (count_q == '0);
  assign flagLast  = (state == ST_RUN) && (count_q == last_idx);
  assign flagReady = (state == ST_DONE);
  assign start_err = start_err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_booth_step_sequencer.sv
// Directed bench for booth_step_sequencer. A table of per-cycle vectors holds the
// inputs driven before each rising edge and the outputs expected after that edge.
// A hand-written stalled run follows the table.
module tb_booth_step_sequencer;

  localparam int NB = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NB-1:0] term_count = '0;
  logic          enable = 1'b0;
  logic          abort = 1'b0;
  logic          auto_restart = 1'b0;
  logic [NB-1:0] count;
  logic          busy, flag_start, flag_last, flag_ready, start_err;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  booth_step_sequencer #(.MAX_COUNT(32)) dut (
    .clk(clk), .reset(reset), .start(start), .term_count(term_count),
    .enable(enable), .abort(abort), .auto_restart(auto_restart),
    .count(count), .busy(busy), .flagStart(flag_start), .flagLast(flag_last),
    .flagReady(flag_ready), .start_err(start_err), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          st;
    logic [NB-1:0] tc;
    logic          en;
    logic          ab;
    logic          ar;
    logic [NB-1:0] cnt;
    logic          bsy;
    logic          fs;
    logic          fl;
    logic          fr;
    logic          se;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic rst, input logic st, input int tc,
                            input logic en, input logic ab, input logic ar,
                            input int cnt, input logic bsy, input logic fs,
                            input logic fl, input logic fr, input logic se);
    vec_t x;
    x.rst = rst; x.st = st; x.tc = NB'(tc); x.en = en; x.ab = ab; x.ar = ar;
    x.cnt = NB'(cnt); x.bsy = bsy; x.fs = fs; x.fl = fl; x.fr = fr; x.se = se;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // driver: apply one vector, step one edge, sample 1 time unit after it
  task automatic apply(input vec_t x);
    reset = x.rst; start = x.st; term_count = x.tc;
    enable = x.en; abort = x.ab; auto_restart = x.ar;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int max_cnt;
    bit seen_ready;

    // Scenario 1: reset, then N=4 with enable held high
    v(1,0,0,1,0,0, 0,0,0,0,0,0);
    v(0,0,0,1,1,0, 0,0,0,0,0,0);   // abort in IDLE does nothing
    v(0,1,4,1,0,0, 0,1,1,0,0,0);
    v(0,0,9,1,0,0, 1,1,0,0,0,0);
    v(0,0,9,1,0,0, 2,1,0,0,0,0);
    v(0,0,9,1,0,0, 3,1,0,1,0,0);
    v(0,0,0,1,0,0, 0,1,0,0,1,0);
    v(0,0,0,1,0,0, 0,0,0,0,0,0);
    v(0,1,3,1,1,0, 0,0,0,0,0,0);   // start blocked by abort in IDLE
    // Scenario 2a: term_count=0 is treated as a single step
    v(0,1,0,1,0,0, 0,1,1,1,0,0);
    v(0,0,0,1,0,0, 0,1,0,0,1,0);
    v(0,0,0,1,0,0, 0,0,0,0,0,0);
    // Scenario 2b: term_count=40 is clamped to 32 steps
    v(0,1,40,1,0,0, 0,1,1,0,0,0);
    for (int i = 1; i <= 30; i++) v(0,0,0,1,0,0, i,1,0,0,0,0);
    v(0,0,0,1,0,0, 31,1,0,1,0,0);
    v(0,0,0,1,0,0, 0,1,0,0,1,0);
    v(0,0,0,1,0,0, 0,0,0,0,0,0);
    // Scenario 3: N=6, enable low for 3 cycles at count=2
    v(0,1,6,1,0,0, 0,1,1,0,0,0);
    v(0,0,0,1,0,0, 1,1,0,0,0,0);
    v(0,0,0,1,0,0, 2,1,0,0,0,0);
    for (int i = 0; i < 3; i++) v(0,0,0,0,0,0, 2,1,0,0,0,0);
    v(0,0,0,1,0,0, 3,1,0,0,0,0);
    v(0,0,0,1,0,0, 4,1,0,0,0,0);
    v(0,0,0,1,0,0, 5,1,0,1,0,0);
    v(0,0,0,1,0,0, 0,1,0,0,1,0);
    v(0,0,0,1,0,0, 0,0,0,0,0,0);
    // Scenario 4: N=8, abort at count=5, then reset during a new run
    v(0,1,8,1,0,0, 0,1,1,0,0,0);
    for (int i = 1; i <= 5; i++) v(0,0,0,1,0,0, i,1,0,0,0,0);
    v(0,1,2,1,1,0, 0,0,0,0,0,0);   // abort wins over enable and start
    v(0,0,0,1,0,0, 0,0,0,0,0,0);
    v(0,1,8,1,0,0, 0,1,1,0,0,0);
    v(0,0,0,1,0,0, 1,1,0,0,0,0);
    v(0,0,0,1,0,0, 2,1,0,0,0,0);
    v(1,0,0,1,0,0, 0,0,0,0,0,0);
    v(0,0,0,1,0,0, 0,0,0,0,0,0);
    // Scenario 5: auto_restart with N=3, then a new start in DONE with N=5
    v(0,1,3,1,0,1, 0,1,1,0,0,0);
    v(0,0,0,1,0,1, 1,1,0,0,0,0);
    v(0,0,0,1,0,1, 2,1,0,1,0,0);
    v(0,0,0,1,0,1, 0,1,0,0,1,0);
    v(0,0,0,1,0,1, 0,1,1,0,0,0);
    v(0,0,0,1,0,1, 1,1,0,0,0,0);
    v(0,0,0,1,0,1, 2,1,0,1,0,0);
    v(0,0,0,1,0,1, 0,1,0,0,1,0);
    v(0,1,5,1,0,0, 0,1,1,0,0,0);   // start in DONE: no error
    v(0,0,0,1,0,0, 1,1,0,0,0,0);
    v(0,0,0,1,0,0, 2,1,0,0,0,0);
    v(0,0,0,1,0,0, 3,1,0,0,0,0);
    v(0,0,0,1,0,0, 4,1,0,1,0,0);
    v(0,0,0,1,0,0, 0,1,0,0,1,0);
    v(0,0,0,1,0,0, 0,0,0,0,0,0);
    // Scenario 6: start during RUN at count=1 (N=4) is rejected
    v(0,1,4,1,0,0, 0,1,1,0,0,0);
    v(0,0,0,1,0,0, 1,1,0,0,0,0);
    v(0,1,7,1,0,0, 2,1,0,0,0,1);
    v(0,0,0,1,0,0, 3,1,0,1,0,0);
    v(0,0,0,1,0,0, 0,1,0,0,1,0);
    v(0,0,0,1,0,0, 0,0,0,0,0,0);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check($sformatf("v%0d count", i), int'(count), int'(vecs[i].cnt));
      check($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].bsy));
      check($sformatf("v%0d flagStart", i), int'(flag_start), int'(vecs[i].fs));
      check($sformatf("v%0d flagLast", i), int'(flag_last), int'(vecs[i].fl));
      check($sformatf("v%0d flagReady", i), int'(flag_ready), int'(vecs[i].fr));
      check($sformatf("v%0d start_err", i), int'(start_err), int'(vecs[i].se));
    end

    // Hand sequence: N=5 with enable stalling every third cycle. The run must
    // reach DONE within the cycle budget and the count must stay within 0..4.
    reset = 1'b0; abort = 1'b0; auto_restart = 1'b0;
    start = 1'b1; term_count = NB'(5); enable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; term_count = NB'(20);
    max_cnt = int'(count);
    seen_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen_ready; cyc++) begin
      enable = ((cyc % 3) != 2);
      @(posedge clk); #1;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (flag_ready) begin
        seen_ready = 1'b1;
        check("stall run state_dbg in DONE", int'(state_dbg), 2);
      end
    end
    check("stall run reached DONE", int'(seen_ready), 1);
    check("stall run max count", max_cnt, 4);
    enable = 1'b1;
    @(posedge clk); #1;
    check("stall run back to IDLE", int'(state_dbg), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_step_sequencer.md
Name: booth_step_sequencer

Overview:
- Parametrised successor to the team's fixed-length counter-with-flags.
- Sequences the iteration steps of the Booth multiplier datapath.
- Adds a run-time programmable step count latched on a start handshake, stall, abort, one-shot/auto-restart modes, and a done pulse.
- Sits between the multiplier control FSM and the shift/add datapath.

Parameters:
- MAX_COUNT, 32, largest step count accepted; term_count values above this are clamped.
- NBITS, ceil(log2(MAX_COUNT+1)) (6 at default), width of term_count and count.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new sequence; term_count is sampled in the same cycle.
- term_count  in  NBITS  number of steps N for the requested sequence.
- enable  in  1  advance one step when high; stall when low.
- abort  in  1  cancel the running sequence.
- auto_restart  in  1  mode: 1 = rerun the latched N immediately after DONE.
- count  out  NBITS  current step index, 0..N-1.
- busy  out  1  high in RUN and DONE.
- flagStart  out  1  high while in RUN with count==0.
- flagLast  out  1  high while in RUN with count==N-1.
- flagReady  out  1  one-cycle pulse while in DONE.
- start_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Synchronous active-high reset, applied on the next clk edge, including mid-operation.
  - Reset forces state=IDLE, count=0, latched N=1.
  - All flags and busy go 0; start_err=0.
- All outputs are registered state or pure decodes of registered state. No input-to-output combinational path.
- N latch: on an accepted start, N_lat = clamp(term_count).
  - term_count 0 → 1.
  - term_count > MAX_COUNT → MAX_COUNT.
- IDLE:
  - count=0, busy=0.
  - start=1 and abort=0 → RUN next cycle with count=0.
  - abort=1 in IDLE → no effect.
- RUN:
  - abort=1 → IDLE next cycle, count=0, no flagReady. Abort has priority over enable and start.
  - enable=1 and count==N_lat-1 → DONE next cycle, count=0.
  - enable=1 otherwise → count+1.
  - enable=0 → count and state hold.
  - start=1 → ignored; start_err=1 in the next cycle.
- DONE (exactly one cycle):
  - flagReady=1, busy=1, count=0.
  - Priority of exits, highest first:
    1. abort → IDLE.
    2. start → RUN with a newly latched N (back-to-back, no bubble; start is not an error here).
    3. auto_restart → RUN with the same N_lat.
    4. Otherwise → IDLE.
- Latency, with enable held high:
  - start sampled at edge t.
  - busy/flagStart from t+1.
  - flagLast at t+N.
  - flagReady at t+N+1.
  - IDLE at t+N+2.
- N_lat=1: flagStart and flagLast are high in the same cycle.
- count never exceeds N_lat-1. No wrap-around beyond N_lat.
- Changes on term_count while busy have no effect.

Test Plan:
1. reset, then start with term_count=4, enable=1 → count 0,1,2,3. flagStart at the first RUN cycle. flagLast with count=3. flagReady one cycle later. IDLE after that; busy high for exactly 5 cycles.
2. term_count=0, then separately term_count=40 (MAX_COUNT=32) → sequences of 1 step (flagStart & flagLast together) and 32 steps (last count=31).
3. N=6, enable low for 3 cycles when count=2 → count holds at 2 for 3 cycles. flagReady is delayed by exactly 3 cycles versus scenario 1 timing.
4. N=8, abort at count=5 → IDLE next cycle, count=0, flagReady never asserts. Then reset asserted mid-RUN of a new sequence → IDLE and all flags 0 on the next edge.
5. auto_restart=1, N=3 → repeating pattern count 0,1,2 then DONE (flagReady) with no idle cycles between. Start in DONE with term_count=5 → next run is 5 steps.
6. start pulsed while in RUN at count=1 (N=4) → start_err pulse the next cycle. The sequence completes unaffected with N=4.
